pipeline_controller: RTL
========================

# pipeline_controller

Central stall/flush sequencer for the five-stage pipeline. Takes hazard information from the ID, EX and MEM stages plus the data-memory handshake, and drives the pipeline-register write enables and flushes (pcWrite, ifIdWrite, ...). It also tracks a halt drain, a memory-wait watchdog and a saturating stall-cycle counter for debug LEDs.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive memReady-low cycles before the controller faults.
- DRAIN_CYCLES, 3: cycles allowed for older instructions to retire after a halt is decoded.
- COUNT_WIDTH, 16: width of stallCycles.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- idRs, idRt  in  5  source registers of the instruction in ID.
- idUsesRt  in  1  the ID instruction reads rt.
- idHalt  in  1  the ID instruction is HALT.
- idExMemRead  in  1  the EX-stage instruction is a load.
- idExRt  in  5  destination of the EX-stage load.
- exBranchTaken  in  1  the branch/jump resolved in EX is taken.
- exMemAccess  in  1  the MEM stage holds a load or store.
- memReady  in  1  data memory completes the access this cycle.
- pcWrite, ifIdWrite, idExWrite, exMemWrite  out  1  stage enables.
- ifIdFlush, idExBubble, memWbBubble  out  1  insert a NOP into that register.
- halted  out  1  the pipeline is stopped (HALT reached or watchdog fault).
- fault  out  1  watchdog fault flag.
- stallCycles  out  COUNT_WIDTH  saturating count of cycles with pcWrite=0 while not halted.

## Operation
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED, FAULT. Outputs are combinational from state and inputs.
- Default (RUN, no hazard): all *Write=1, all flush/bubble=0.
- Priority within RUN, highest first:
  1. Memory wait: exMemAccess && !memReady. Outputs: pcWrite=ifIdWrite=idExWrite=exMemWrite=0, memWbBubble=1. Next state is MEM_WAIT.
  2. Taken branch: exBranchTaken. Outputs: pcWrite=1, ifIdFlush=1, idExBubble=1. This overrides any load-use condition.
  3. Load-use: idExMemRead && idExRt!=0 && (idExRt==idRs || (idUsesRt && idExRt==idRt)). Outputs: pcWrite=ifIdWrite=0, idExBubble=1, for exactly one cycle.
  4. idHalt, with none of 1–3 active. Outputs: pcWrite=0, ifIdFlush=1. Next state is DRAIN with the drain counter loaded to DRAIN_CYCLES.
- MEM_WAIT:
  - Outputs as in memory wait.
  - Wait counter increments every cycle.
  - memReady=1: release this cycle with full RUN evaluation; next state is RUN and the wait counter clears.
  - Counter reaches MEM_TIMEOUT with memReady still 0: next state is FAULT.
- DRAIN:
  - Outputs: pcWrite=ifIdWrite=0, idExBubble=1, later stages enabled.
  - Memory wait still freezes the later stages; the drain counter does not decrement while frozen.
  - Counter reaches 0: next state is HALTED.
  - exBranchTaken is ignored.
- HALTED / FAULT:
  - Outputs: all *Write=0, all flush/bubble=1, halted=1; fault=1 in FAULT only.
  - Both states are sticky until reset.
- stallCycles: increments when pcWrite=0, state is not HALTED/FAULT, and reset=0. It saturates at all-ones.

## Timing
- The controller has no added latency: hazard outputs respond in the same cycle as the inputs.
- While reset=1 (and after the edge that samples it):
  - state=RUN; counters=0; halted=0; fault=0.
  - Outputs forced to pcWrite=ifIdWrite=idExWrite=exMemWrite=0 and ifIdFlush=idExBubble=memWbBubble=1, so the pipeline fills with NOPs.
- A reset asserted mid-MEM_WAIT or mid-DRAIN abandons the state at the next edge. No partial counts survive.
- memReady high in the same cycle that exMemAccess rises is not a stall.
- Load-use alone always costs exactly 1 cycle.
- A taken branch costs 2 flushed slots.

## Structure
- Shared package: state encoding, a NOP-insertion constant, and a REG_ZERO=5'd0 constant.
- One natural sub-module: hazard_detect. It is the pure combinational load-use comparator (idRs, idRt, idUsesRt, idExMemRead, idExRt → loadUse).
- The FSM, counters and output mux live in pipeline_controller.

## Test plan
- Load-use: idExMemRead=1, idExRt=5, idRs=5 → one cycle of pcWrite=0, ifIdWrite=0, idExBubble=1, then RUN; stallCycles=1. Repeat with idExRt=0 → no stall.
- Branch vs load-use: exBranchTaken=1 together with a load-use match → pcWrite=1, ifIdFlush=1, idExBubble=1, no stall.
- Memory wait: exMemAccess=1 with memReady low for 4 cycles → all four enables 0 and memWbBubble=1 for 4 cycles; release on the 5th cycle; stallCycles=4.
- Watchdog: with MEM_TIMEOUT=8, memReady held low → fault=1 and halted=1 after 8 wait cycles and stay set; reset → all clear.
- Halt: idHalt=1 → DRAIN for 3 cycles (extended by 2 cycles of injected memory wait) → halted=1, pcWrite=0 thereafter.
- Reset mid-DRAIN: outputs go to the reset values on the next edge; after release the FSM is in RUN with stallCycles=0.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// rtl/pipeline_controller_pkg.sv - shared state encoding and constants for the pipeline stall/flush controller
package pipeline_controller_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    FAULT    = 3'd4
  } ctrlState_t;

  // Value driven onto a flush/bubble line to squash the instruction in that register.
  localparam logic NOP_INSERT = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// rtl/pipeline_controller_hazard_detect.sv - combinational load-use comparator between the ID instruction and the EX load
module pipeline_controller_hazard_detect
  import pipeline_controller_pkg::*;
(
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRt,
  input  logic       idExMemRead,
  input  logic [4:0] idExRt,
  output logic       loadUse
);

  // r0 is hard-wired, so a load targeting it never creates a dependency.
  assign loadUse = idExMemRead && (idExRt != REG_ZERO) &&
                   ((idExRt == idRs) || (idUsesRt && (idExRt == idRt)));

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - stall/flush sequencer with halt drain, memory-wait watchdog and stall counter
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 3,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             idRs,
  input  logic [4:0]             idRt,
  input  logic                   idUsesRt,
  input  logic                   idHalt,
  input  logic                   idExMemRead,
  input  logic [4:0]             idExRt,
  input  logic                   exBranchTaken,
  input  logic                   exMemAccess,
  input  logic                   memReady,
  output logic                   pcWrite,
  output logic                   ifIdWrite,
  output logic                   idExWrite,
  output logic                   exMemWrite,
  output logic                   ifIdFlush,
  output logic                   idExBubble,
  output logic                   memWbBubble,
  output logic                   halted,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] stallCycles
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrlState_t          state, nextState;
  logic [WAIT_W-1:0]   waitCnt;
  logic [DRAIN_W-1:0]  drainCnt;
  logic                loadUse;
  logic                memWaitReq;
  logic                memStall;
  logic                inMain;

  pipeline_controller_hazard_detect uHazard (
    .idRs        (idRs),
    .idRt        (idRt),
    .idUsesRt    (idUsesRt),
    .idExMemRead (idExMemRead),
    .idExRt      (idExRt),
    .loadUse     (loadUse)
  );

  assign memWaitReq = exMemAccess && !memReady;
  assign inMain     = (state == RUN) || (state == MEM_WAIT);
  // Once waiting, only memReady releases the stall; exMemAccess may drop meanwhile.
  assign memStall   = (state == MEM_WAIT) ? !memReady : memWaitReq;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      RUN, MEM_WAIT: begin
        if (memStall) begin
          nextState = ((state == MEM_WAIT) && (waitCnt >= WAIT_LAST)) ? FAULT : MEM_WAIT;
        end else if (exBranchTaken || loadUse) begin
          nextState = RUN;
        end else if (idHalt) begin
          nextState = DRAIN;
        end else begin
          nextState = RUN;
        end
      end
      DRAIN: begin
        if (!memWaitReq && (drainCnt <= DRAIN_W'(1))) begin
          nextState = HALTED;
        end
      end
      HALTED, FAULT: nextState = state;
      default:       nextState = RUN;
    endcase
  end

  always_comb begin
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    idExWrite   = 1'b1;
    exMemWrite  = 1'b1;
    ifIdFlush   = 1'b0;
    idExBubble  = 1'b0;
    memWbBubble = 1'b0;
    halted      = 1'b0;
    fault       = 1'b0;
    if (reset || (state == HALTED) || (state == FAULT)) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      exMemWrite  = 1'b0;
      ifIdFlush   = NOP_INSERT;
      idExBubble  = NOP_INSERT;
      memWbBubble = NOP_INSERT;
      halted      = !reset;
      fault       = !reset && (state == FAULT);
    end else if (state == DRAIN) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = NOP_INSERT;
      if (memWaitReq) begin
        idExWrite   = 1'b0;
        exMemWrite  = 1'b0;
        memWbBubble = NOP_INSERT;
      end
    end else if (memStall) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      exMemWrite  = 1'b0;
      memWbBubble = NOP_INSERT;
    end else if (exBranchTaken) begin
      ifIdFlush  = NOP_INSERT;
      idExBubble = NOP_INSERT;
    end else if (loadUse) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = NOP_INSERT;
    end else if (idHalt) begin
      pcWrite   = 1'b0;
      ifIdFlush = NOP_INSERT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !inMain || !memStall) begin
      waitCnt <= '0;
    end else begin
      waitCnt <= waitCnt + WAIT_W'(1);
    end
  end

  // Drain only counts cycles in which the older instructions can actually advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      drainCnt <= '0;
    end else if ((state != DRAIN) && (nextState == DRAIN)) begin
      drainCnt <= DRAIN_W'(DRAIN_CYCLES);
    end else if ((state == DRAIN) && !memWaitReq && (drainCnt != '0)) begin
      drainCnt <= drainCnt - DRAIN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCycles <= '0;
    end else if (!pcWrite && (state != HALTED) && (state != FAULT) && (stallCycles != '1)) begin
      stallCycles <= stallCycles + COUNT_WIDTH'(1);
    end
  end

endmodule
